dmem_copy_engine: RTL

- Bus-initiator sequencer that drives the data-memory port (read enable, write enable, address, write data) and consumes its combinational read data.
- Copies a block of LEN bytes from SRC to DST, one byte per READ/WRITE cycle pair, with a start/busy/done handshake toward the control unit.
- Sits between the control FSM and dmem; it is the master side of the dmem interface.

---
 rtl/dmem_copy_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
// ----------------
// Bus-initiator sequencer that copies a block of bytes inside the data memory.
// One byte moves per READ/WRITE cycle pair, from src..src+len-1 to
// dst..dst+len-1. All addresses wrap modulo DEPTH. The copy runs strictly
// forward, so an overlapping destination above the source re-reads bytes it
// has already written, which smears them.
//
// Optional feature: define COPY_CHECKSUM_EN to add a running mod-2^DW sum of
// every byte read. The sum clears on an accepted start.
//
// Ports:
//   clock      in   rising-edge clock
//   clear_n    in   synchronous active-low reset
//   start      in   request pulse, honoured only in IDLE
//   src_addr   in   source base address (captured on accepted start)
//   dst_addr   in   destination base address (captured on accepted start)
//   length     in   byte count 0..63, clamped to DEPTH (captured on start)
//   busy       out  high whenever the engine is not IDLE
//   done       out  one-cycle pulse at the end of an operation
//   mem_read   out  dmem read enable
//   mem_write  out  dmem write enable
//   mem_addr   out  dmem address
//   mem_wdata  out  dmem write data
//   checksum   out  (COPY_CHECKSUM_EN only) sum of bytes read
//   mem_rdata  in   dmem read data, combinational, same cycle
module dmem_copy_engine #(
    parameter int DEPTH = 32,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          clear_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [5:0]    length,
    output logic          busy,
    output logic          done,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef COPY_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    // DEPTH is a power of two, so masking gives the modulo-DEPTH wrap.
    localparam logic [AW-1:0] AMASK = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [5:0]    len;
    logic [5:0]    idx;
    logic [DW-1:0] hold;
    logic [5:0]    len_in;
    logic          accept;

    // The length port tops out at 63, so the clamped count always fits in 6 bits.
    assign len_in = (int'(length) > DEPTH) ? 6'(DEPTH) : length;
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode only from registered state, idx and hold. start affects
    // nothing except the next-state choice.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_in == 6'd0) ? DONE : READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = (src + AW'(idx)) & AMASK;
                state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = (dst + AW'(idx)) & AMASK;
                mem_wdata  = hold;
                state_next = ((idx + 6'd1) == len) ? DONE : READ;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            src  <= '0;
            dst  <= '0;
            len  <= '0;
            idx  <= '0;
            hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src <= src_addr & AMASK;
                        dst <= dst_addr & AMASK;
                        len <= len_in;
                        idx <= '0;
                    end
                end
                READ:    hold <= mem_rdata;
                WRITE:   idx  <= idx + 6'd1;
                default: ;
            endcase
        end
    end

`ifdef COPY_CHECKSUM_EN
    logic [DW-1:0] sum;

    // The sum holds its value from DONE until the next accepted start.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (state == READ) begin
            sum <= sum + mem_rdata;
        end
    end

    assign checksum = sum;
`endif

endmodule
